joystick_repeat: RTL and testbench

- Downstream of the joystick debouncer; consumes its five debounced level signals (up/down/left/right/fire).
- Converts each held level into single-cycle action pulses for the game FSM: one pulse on press, then auto-repeat after an initial delay at a fixed period while held (typematic behaviour).
- Masks contradictory direction pairs so the game logic never sees up+down or left+right together.

---
 rtl/joystick_pkg.sv | 18 +
 rtl/joystick_repeat_channel.sv | 75 +++++++
 rtl/joystick_repeat.sv | 67 ++++++
 tb/tb_joystick_repeat.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/joystick_pkg.sv
// Shared types and bit indices for the joystick auto-repeat block.
package joystick_pkg;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

    // Bit positions inside o_held and the internal level/pulse vectors
    localparam int JOY_UP    = 4;
    localparam int JOY_DOWN  = 3;
    localparam int JOY_LEFT  = 2;
    localparam int JOY_RIGHT = 1;
    localparam int JOY_FIRE  = 0;
    localparam int JOY_N     = 5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/joystick_repeat_channel.sv
// One typematic channel: pulse on press, then delayed auto-repeat while held.
// With REPEAT_EN = 0 the channel pulses once per press and the counter is unused.
module repeat_channel
    import joystick_pkg::*;
#(
    parameter int DELAY_CYC  = 12_500_000,
    parameter int PERIOD_CYC = 5_000_000,
    parameter bit REPEAT_EN  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_pulse
);

    localparam int CNT_W = $clog2(max_int(DELAY_CYC, PERIOD_CYC)) + 1;
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DELAY_CYC - 1);
    // REPEAT reloads to 1 and counts up to PERIOD_CYC so repeats land exactly PERIOD_CYC apart
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(PERIOD_CYC);

    rpt_state_t       state;
    logic             prev;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            prev    <= 1'b0;
            cnt     <= '0;
            o_pulse <= 1'b0;
        end else begin
            prev    <= i_level;
            o_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_level && !prev) begin
                        o_pulse <= 1'b1;
                        state   <= DELAY;
                        if (REPEAT_EN) cnt <= CNT_W'(1);
                    end
                end
                DELAY: begin
                    if (!i_level) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (REPEAT_EN) begin
                        if (cnt == DLY_LAST) begin
                            o_pulse <= 1'b1;
                            state   <= REPEAT;
                            cnt     <= CNT_W'(1);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (!i_level) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == PER_LAST) begin
                        o_pulse <= 1'b1;
                        cnt     <= CNT_W'(1);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/joystick_repeat.sv
// Joystick action-pulse generator: masks opposite directions and runs five repeat channels.
// Define JOYSTICK_FIRE_REPEAT_EN to make fire auto-repeat like the directions.
module joystick_repeat
    import joystick_pkg::*;
#(
    parameter int DELAY_CYC  = 12_500_000,
    parameter int PERIOD_CYC = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_fire,
    output logic       o_up_pulse,
    output logic       o_down_pulse,
    output logic       o_left_pulse,
    output logic       o_right_pulse,
    output logic       o_fire_pulse,
    output logic [4:0] o_held
);

`ifdef JOYSTICK_FIRE_REPEAT_EN
    localparam bit FIRE_RPT = 1'b1;
`else
    localparam bit FIRE_RPT = 1'b0;
`endif

    logic [JOY_N-1:0] lvl;
    logic [JOY_N-1:0] pulse;

    // Opposite pairs cancel so the game never sees both directions at once
    always_comb begin
        lvl            = '0;
        lvl[JOY_UP]    = i_up    & ~i_down;
        lvl[JOY_DOWN]  = i_down  & ~i_up;
        lvl[JOY_LEFT]  = i_left  & ~i_right;
        lvl[JOY_RIGHT] = i_right & ~i_left;
        lvl[JOY_FIRE]  = i_fire;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) o_held <= '0;
        else     o_held <= lvl;
    end

    for (genvar i = 0; i < JOY_N; i++) begin : g_ch
        repeat_channel #(
            .DELAY_CYC (DELAY_CYC),
            .PERIOD_CYC(PERIOD_CYC),
            .REPEAT_EN ((i == JOY_FIRE) ? FIRE_RPT : 1'b1)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .i_level(lvl[i]),
            .o_pulse(pulse[i])
        );
    end

    assign o_up_pulse    = pulse[JOY_UP];
    assign o_down_pulse  = pulse[JOY_DOWN];
    assign o_left_pulse  = pulse[JOY_LEFT];
    assign o_right_pulse = pulse[JOY_RIGHT];
    assign o_fire_pulse  = pulse[JOY_FIRE];

endmodule

// File: tb/tb_joystick_repeat.sv
// Directed bench for joystick_repeat with DELAY_CYC=8, PERIOD_CYC=4; expected pulse cycles hand-listed.
module tb_joystick_repeat;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_up = 1'b0, i_down = 1'b0, i_left = 1'b0, i_right = 1'b0, i_fire = 1'b0;
    logic       o_up_pulse, o_down_pulse, o_left_pulse, o_right_pulse, o_fire_pulse;
    logic [4:0] o_held;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    joystick_repeat #(.DELAY_CYC(8), .PERIOD_CYC(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_up         (i_up),
        .i_down       (i_down),
        .i_left       (i_left),
        .i_right      (i_right),
        .i_fire       (i_fire),
        .o_up_pulse   (o_up_pulse),
        .o_down_pulse (o_down_pulse),
        .o_left_pulse (o_left_pulse),
        .o_right_pulse(o_right_pulse),
        .o_fire_pulse (o_fire_pulse),
        .o_held       (o_held)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] pulses();
        return {o_up_pulse, o_down_pulse, o_left_pulse, o_right_pulse, o_fire_pulse};
    endfunction

    // Input levels {up,down,left,right,fire} for scenario s in cycle c
    function automatic logic [4:0] drive(input int s, input int c);
        logic [4:0] v;
        v = '0;
        case (s)
            0: v[4] = (c >= 10 && c <= 40);
            1: v[2] = (c >= 10 && c <= 14) || (c >= 20 && c <= 22);
            2: begin
                v[4] = (c >= 10 && c <= 40);
                v[3] = (c >= 20 && c <= 30);
            end
            3: v[0] = (c >= 10 && c <= 40);
            4: v[1] = (c >= 10 && c <= 38);
            5: begin
                v[2] = (c >= 10 && c <= 30);
                v[0] = (c >= 10 && c <= 30);
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [4:0] exp_pulse(input int s, input int c);
        logic [4:0] e;
        e = '0;
        case (s)
            0: e[4] = c inside {11, 18, 22, 26, 30, 34, 38};
            1: e[2] = c inside {11, 21};
            2: e[4] = c inside {11, 18, 32, 39};
`ifdef JOYSTICK_FIRE_REPEAT_EN
            3: e[0] = c inside {11, 18, 22, 26, 30, 34, 38};
`else
            3: e[0] = (c == 11);
`endif
            4: e[1] = c inside {11, 18, 26, 33, 37};
            5: begin
                e[2] = c inside {11, 18, 22, 26, 30};
`ifdef JOYSTICK_FIRE_REPEAT_EN
                e[0] = c inside {11, 18, 22, 26, 30};
`else
                e[0] = (c == 11);
`endif
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic [4:0] exp_held(input int s, input int c);
        logic [4:0] e;
        e = '0;
        case (s)
            0: e[4] = (c >= 11 && c <= 41);
            1: e[2] = (c >= 11 && c <= 15) || (c >= 21 && c <= 23);
            2: e[4] = (c >= 11 && c <= 20) || (c >= 32 && c <= 41);
            3: e[0] = (c >= 11 && c <= 41);
            4: e[1] = (c >= 11 && c <= 20) || (c >= 26 && c <= 39);
            5: begin
                e[2] = (c >= 11 && c <= 31);
                e[0] = (c >= 11 && c <= 31);
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic set_in(input logic [4:0] v);
        {i_up, i_down, i_left, i_right, i_fire} = v;
    endtask

    task automatic run(input int s);
        logic [4:0] v;
        set_in('0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk($sformatf("s%0d_rst_pulse", s), 32'(pulses()), 32'h0);
        chk($sformatf("s%0d_rst_held", s), 32'(o_held), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c <= 45; c++) begin
            v = drive(s, c);
            set_in(v);
            if (s == 4) rst = (c >= 21 && c <= 24);
            #1;
            chk($sformatf("s%0d_c%0d_pulse", s, c), 32'(pulses()), 32'(exp_pulse(s, c)));
            chk($sformatf("s%0d_c%0d_held", s, c), 32'(o_held), 32'(exp_held(s, c)));
            if (s == 4 && c == 18) begin
                // reset lands mid-cycle, clearing outputs without waiting for an edge
                #2 rst = 1'b1;
                #1;
                chk("s4_async_pulse", 32'(pulses()), 32'h0);
                chk("s4_async_held", 32'(o_held), 32'h0);
                rst = 1'b0;
            end
            if (s == 4 && c == 20) begin
                #2 rst = 1'b1;
                #1;
                chk("s4_async2_pulse", 32'(pulses()), 32'h0);
                chk("s4_async2_held", 32'(o_held), 32'h0);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int s = 0; s <= 5; s++) begin
            if (s == 4) run_reset_only();
            else run(s);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Scenario 4 without the early cycle-18 glitch: one clean mid-hold reset in cycle 20
    task automatic run_reset_only();
        logic [4:0] v;
        set_in('0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("s4_rst_pulse", 32'(pulses()), 32'h0);
        chk("s4_rst_held", 32'(o_held), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c <= 45; c++) begin
            v = drive(4, c);
            set_in(v);
            rst = (c >= 21 && c <= 24);
            #1;
            chk($sformatf("s4_c%0d_pulse", c), 32'(pulses()), 32'(exp_pulse(4, c)));
            chk($sformatf("s4_c%0d_held", c), 32'(o_held), 32'(exp_held(4, c)));
            if (c == 20) begin
                #2 rst = 1'b1;
                #1;
                chk("s4_async_pulse", 32'(pulses()), 32'h0);
                chk("s4_async_held", 32'(o_held), 32'h0);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=%0d exp=%0d", n_cmp, 0);
        $fatal(1, "timeout");
    end

endmodule
